hilo_scheduler: RTL and testbench
=================================

# hilo_scheduler

Sequencing controller for the shared HI/LO result path of the multicycle datapath. Accepts MULT, DIV, MTHI and MTLO operations from the main control unit and drives the enable (DivCtrl-style) of the iterative divider or the multiplier for exactly the required number of cycles. It then commits the unit's HI/LO outputs into the architectural HI/LO registers and flags divide-by-zero. It also stalls MFHI/MFLO reads while a result is in flight.

## Interface
Parameters:
- DIV_CYCLES, 36, cycles div_ctrl is held high: load 1, iterate 33, writeback 1, drain 1.
- MULT_CYCLES, 34, cycles mult_ctrl is held high.
- CNT_W, 6, width of the internal cycle counter; must hold max(DIV_CYCLES, MULT_CYCLES).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low; also routed to both arithmetic units.
- op_valid  in  1  operation request.
- op_ready  out  1  scheduler can accept; high only in IDLE.
- op_kind  in  2  00 MULT, 01 DIV, 10 MTHI, 11 MTLO.
- op_data  in  32  write value for MTHI/MTLO.
- div_ctrl  out  1  divider enable.
- mult_ctrl  out  1  multiplier enable.
- div_zero  in  1  divider zero-divisor flag.
- div_hi, div_lo  in  32  divider remainder/quotient.
- mult_hi, mult_lo  in  32  multiplier product halves.
- rd_req  in  1  MFHI/MFLO in decode.
- stall  out  1  hold the pipeline.
- hi, lo  out  32  architectural HI/LO.
- busy  out  1  unit operation in flight.
- div_zero_exc  out  1  one-cycle exception pulse.

## Operation
- States: IDLE, DIV_RUN, MULT_RUN, COMMIT.
- IDLE: accept on op_valid && op_ready.
  - MTHI/MTLO: write op_data into hi/lo at that edge; stay in IDLE.
  - DIV: go to DIV_RUN and clear the counter.
  - MULT: go to MULT_RUN and clear the counter.
- DIV_RUN:
  - div_ctrl=1 and the counter increments every cycle.
  - When counter==1 and div_zero=1: abort to IDLE, drop div_ctrl, pulse div_zero_exc for one cycle. hi/lo are unchanged.
  - When counter==DIV_CYCLES-1: go to COMMIT.
- MULT_RUN: same as DIV_RUN without the zero check; exit at MULT_CYCLES-1.
- COMMIT:
  - Both enables are 0.
  - At the edge, load hi/lo from the source unit (div_* or mult_*), selected by a registered source bit.
  - Go to IDLE.
- busy: high in DIV_RUN, MULT_RUN and COMMIT.
- stall = rd_req && busy.
- op_valid while not ready: held by the requester and not dropped; the scheduler ignores it until op_ready.
- Simultaneous rd_req and acceptance in IDLE: no stall; the read sees the pre-operation hi/lo.
- Reset asserted at any time:
  - Immediately go to IDLE; counter 0.
  - div_ctrl, mult_ctrl, busy, stall and div_zero_exc all 0; hi=lo=0.
  - op_ready=1 after release.
- Counter arithmetic is unsigned CNT_W and never wraps.

## Timing
- All outputs are registered except stall.
- Acceptance at edge E0:
  - div_ctrl is high for cycles 1..DIV_CYCLES.
  - COMMIT is cycle DIV_CYCLES+1.
  - New hi/lo are visible from cycle DIV_CYCLES+2, when op_ready=1 again.
  - With defaults, DIV latency is 38 cycles from request to readable result.
- Divide-by-zero: div_zero_exc is high in cycle 3 and op_ready is high in cycle 3. div_ctrl was high in cycles 1–2 only, which leaves the divider in its load state.
- Back-to-back operations: a new op can be accepted in the first IDLE cycle.

## Configuration
- HILO_BYPASS_EN defined:
  - During COMMIT, hi/lo outputs forward the selected unit results combinationally.
  - stall deasserts in COMMIT.
- HILO_BYPASS_EN undefined:
  - hi/lo are purely registered.
  - stall covers COMMIT.

## Structure
- Package hilo_pkg holds the op_kind encoding, the state enum, and the default DIV_CYCLES/MULT_CYCLES constants.
- One sub-module, hilo_op_timer: a loadable counter with a terminal-count flag and a count==1 probe.
- The FSM, HI/LO registers and stall logic live in hilo_scheduler.

## Test plan
- Reset mid-DIV (cycle 10): div_ctrl, busy, hi and lo go to 0 immediately; op_ready=1 after release; a following DIV of 100/7 gives hi=2, lo=14.
- DIV 7 / -2 with the real divider: lo=0xFFFFFFFD and hi=1, readable at cycle 38; div_ctrl high for exactly 36 cycles.
- DIV 5 / 0: div_zero_exc pulses once in cycle 3; hi/lo keep their prior values 0xAAAA0000/0x0000BBBB; op_ready=1 in cycle 3.
- MTHI 0x12345678 then MTLO 0xCAFEBABE on consecutive cycles: both registers update with no busy.
- MULT 0x10000 x 0x10000: hi=1, lo=0; rd_req held throughout the run gives stall for cycles 1..35.
  - With HILO_BYPASS_EN, stall ends at cycle 35, i.e. only cycles 1..34.
- rd_req and op_valid (DIV) in the same IDLE cycle: no stall; the read returns the old hi/lo.

Source files
------------

// File: rtl/hilo_pkg.sv
// Shared types and default timing constants for the HI/LO result-path scheduler.
// The optional HILO_BYPASS_EN build macro is consumed by hilo_scheduler.
package hilo_pkg;

  typedef enum logic [1:0] {
    OP_MULT = 2'b00,
    OP_DIV  = 2'b01,
    OP_MTHI = 2'b10,
    OP_MTLO = 2'b11
  } op_kind_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_DIV_RUN  = 2'b01,
    ST_MULT_RUN = 2'b10,
    ST_COMMIT   = 2'b11
  } state_e;

  localparam int DIV_CYCLES_DEF  = 36;
  localparam int MULT_CYCLES_DEF = 34;
  localparam int CNT_W_DEF       = 6;

  // Selects the result word of whichever unit produced the in-flight operation.
  function automatic logic [31:0] pick_unit(input logic        src_div,
                                            input logic [31:0] div_v,
                                            input logic [31:0] mult_v);
    logic [31:0] res;
    if (src_div) begin
      res = div_v;
    end else begin
      res = mult_v;
    end
    return res;
  endfunction

endpackage

// File: rtl/hilo_op_timer.sv
// Loadable up-counter for unit enable windows: flags the terminal count and count==1.
// Saturates at all-ones so it never wraps.
module hilo_op_timer #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] term,
  output logic             at_term,
  output logic             at_one
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] count_r;

  // Cycle counter: cleared on load, saturating increment while enabled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r <= CNT_ZERO;
    end else if (load) begin
      count_r <= CNT_ZERO;
    end else if (en && (count_r != CNT_MAX)) begin
      count_r <= count_r + CNT_ONE;
    end
  end

  assign at_term = (count_r == term);
  assign at_one  = (count_r == CNT_ONE);

endmodule

// File: rtl/hilo_scheduler.sv
// Sequences MULT/DIV/MTHI/MTLO onto the shared HI/LO path and stalls MFHI/MFLO while busy.
// Build option: define HILO_BYPASS_EN to forward unit results during COMMIT.
module hilo_scheduler
  import hilo_pkg::*;
#(
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [1:0]  op_kind,
  input  logic [31:0] op_data,
  output logic        div_ctrl,
  output logic        mult_ctrl,
  input  logic        div_zero,
  input  logic [31:0] div_hi,
  input  logic [31:0] div_lo,
  input  logic [31:0] mult_hi,
  input  logic [31:0] mult_lo,
  input  logic        rd_req,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        div_zero_exc
);

  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_CYCLES - 1);

  state_e      state_r;
  state_e      state_next_s;
  op_kind_e    kind_s;
  logic        accept_s;
  logic        timer_load_s;
  logic        timer_en_s;
  logic        abort_s;
  logic        at_term_s;
  logic        at_one_s;
  logic [CNT_W-1:0] term_s;
  logic [31:0] commit_hi_s;
  logic [31:0] commit_lo_s;

  logic        src_div_r;
  logic        op_ready_r;
  logic        div_ctrl_r;
  logic        mult_ctrl_r;
  logic        busy_r;
  logic        div_zero_exc_r;
  logic [31:0] hi_r;
  logic [31:0] lo_r;

  assign kind_s      = op_kind_e'(op_kind);
  assign accept_s    = op_valid && op_ready_r;
  assign term_s      = src_div_r ? DIV_LAST : MULT_LAST;
  assign commit_hi_s = pick_unit(src_div_r, div_hi, mult_hi);
  assign commit_lo_s = pick_unit(src_div_r, div_lo, mult_lo);

  hilo_op_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (timer_load_s),
    .en      (timer_en_s),
    .term    (term_s),
    .at_term (at_term_s),
    .at_one  (at_one_s)
  );

  // Next-state logic and timer control.
  always_comb begin
    state_next_s = state_r;
    timer_load_s = 1'b0;
    timer_en_s   = 1'b0;
    abort_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          case (kind_s)
            OP_DIV: begin
              state_next_s = ST_DIV_RUN;
              timer_load_s = 1'b1;
            end
            OP_MULT: begin
              state_next_s = ST_MULT_RUN;
              timer_load_s = 1'b1;
            end
            default: state_next_s = ST_IDLE;
          endcase
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_DIV_RUN: begin
        timer_en_s = 1'b1;
        // The divider reports a zero divisor one cycle after its load cycle.
        if (at_one_s && div_zero) begin
          state_next_s = ST_IDLE;
          abort_s      = 1'b1;
        end else if (at_term_s) begin
          state_next_s = ST_COMMIT;
        end else begin
          state_next_s = ST_DIV_RUN;
        end
      end
      ST_MULT_RUN: begin
        timer_en_s = 1'b1;
        if (at_term_s) begin
          state_next_s = ST_COMMIT;
        end else begin
          state_next_s = ST_MULT_RUN;
        end
      end
      ST_COMMIT: state_next_s = ST_IDLE;
      default:   state_next_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Registered control outputs, decoded from the upcoming state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_ready_r     <= 1'b1;
      div_ctrl_r     <= 1'b0;
      mult_ctrl_r    <= 1'b0;
      busy_r         <= 1'b0;
      div_zero_exc_r <= 1'b0;
    end else begin
      op_ready_r     <= (state_next_s == ST_IDLE);
      div_ctrl_r     <= (state_next_s == ST_DIV_RUN);
      mult_ctrl_r    <= (state_next_s == ST_MULT_RUN);
      busy_r         <= (state_next_s != ST_IDLE);
      div_zero_exc_r <= abort_s;
    end
  end

  // Remembers which unit owns the in-flight result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      src_div_r <= 1'b0;
    end else if (accept_s && (kind_s == OP_DIV)) begin
      src_div_r <= 1'b1;
    end else if (accept_s && (kind_s == OP_MULT)) begin
      src_div_r <= 1'b0;
    end
  end

  // Architectural HI/LO: direct moves in IDLE, unit results at COMMIT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_r <= 32'h0000_0000;
      lo_r <= 32'h0000_0000;
    end else if (accept_s && (kind_s == OP_MTHI)) begin
      hi_r <= op_data;
    end else if (accept_s && (kind_s == OP_MTLO)) begin
      lo_r <= op_data;
    end else if (state_r == ST_COMMIT) begin
      hi_r <= commit_hi_s;
      lo_r <= commit_lo_s;
    end
  end

  assign op_ready     = op_ready_r;
  assign div_ctrl     = div_ctrl_r;
  assign mult_ctrl    = mult_ctrl_r;
  assign busy         = busy_r;
  assign div_zero_exc = div_zero_exc_r;

`ifdef HILO_BYPASS_EN
  assign hi    = (state_r == ST_COMMIT) ? commit_hi_s : hi_r;
  assign lo    = (state_r == ST_COMMIT) ? commit_lo_s : lo_r;
  assign stall = rd_req && busy_r && (state_r != ST_COMMIT);
`else
  assign hi    = hi_r;
  assign lo    = lo_r;
  assign stall = rd_req && busy_r;
`endif

endmodule

// File: tb/tb_hilo_scheduler.sv
// Self-checking bench for hilo_scheduler: vector table, hand-written corner sequences
// and randomized operations against an arithmetic reference model.
module tb_hilo_scheduler;

  localparam int DN = 36;
  localparam int MN = 34;
  localparam logic [1:0] K_MULT = 2'b00;
  localparam logic [1:0] K_DIV  = 2'b01;
  localparam logic [1:0] K_MTHI = 2'b10;
  localparam logic [1:0] K_MTLO = 2'b11;
`ifdef HILO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid;
  logic        op_ready;
  logic [1:0]  op_kind;
  logic [31:0] op_data;
  logic        div_ctrl;
  logic        mult_ctrl;
  logic        div_zero;
  logic [31:0] div_hi, div_lo, mult_hi, mult_lo;
  logic        rd_req;
  logic        stall;
  logic [31:0] hi, lo;
  logic        busy;
  logic        div_zero_exc;

  always #5 clk = ~clk;

  hilo_scheduler dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
    .op_kind(op_kind), .op_data(op_data), .div_ctrl(div_ctrl), .mult_ctrl(mult_ctrl),
    .div_zero(div_zero), .div_hi(div_hi), .div_lo(div_lo), .mult_hi(mult_hi),
    .mult_lo(mult_lo), .rd_req(rd_req), .stall(stall), .hi(hi), .lo(lo),
    .busy(busy), .div_zero_exc(div_zero_exc)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] hi_m, lo_m;
  logic [31:0] dv_a = 32'd0, dv_b = 32'd1, mu_a = 32'd0, mu_b = 32'd0;
  int dcnt, mcnt;
  logic [63:0] div_res, mul_res;

  // {remainder, quotient} of a signed divide; zero divisor yields 0
  function automatic logic [63:0] div_ref(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    if (b == 32'd0) begin
      q = 32'd0; r = 32'd0;
    end else begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end
    return {r, q};
  endfunction

  function automatic logic [63:0] mul_ref(input logic [31:0] a, input logic [31:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return p;
  endfunction

  // Unit stand-ins: results only become valid after the full enable window
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      dcnt <= 0; mcnt <= 0;
    end else begin
      if (div_ctrl) dcnt <= dcnt + 1;
      else if (op_valid && op_ready) dcnt <= 0;
      if (mult_ctrl) mcnt <= mcnt + 1;
      else if (op_valid && op_ready) mcnt <= 0;
    end
  end

  assign div_res  = div_ref(dv_a, dv_b);
  assign mul_res  = mul_ref(mu_a, mu_b);
  assign div_zero = (dv_b == 32'd0) && (dcnt >= 1);
  assign div_hi   = (dcnt >= DN) ? div_res[63:32] : 32'hBAD0_0001;
  assign div_lo   = (dcnt >= DN) ? div_res[31:0]  : 32'hBAD0_0002;
  assign mult_hi  = (mcnt >= MN) ? mul_res[63:32] : 32'hBAD0_0003;
  assign mult_lo  = (mcnt >= MN) ? mul_res[31:0]  : 32'hBAD0_0004;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, want %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h, want %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // rd mode: 0 never, 1 always, 2 random, 3 only in the request cycle
  function automatic logic rd_pick(input int mode, input int k);
    case (mode)
      1: return 1'b1;
      2: return 1'($urandom_range(0, 1));
      3: return (k == 0);
      default: return 1'b0;
    endcase
  endfunction

  // Issues one op at posedge+1 and checks every cycle until it has settled in IDLE
  task automatic run_op(input logic [1:0] kind, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo, input bit exc,
                        input int rd_mode);
    logic [31:0] old_hi, old_lo, hi_e, lo_e;
    logic rd;
    int n, last, end_busy;
    bit commit_k, busy_e;
    old_hi = hi_m; old_lo = lo_m;
    op_valid = 1'b1; op_kind = kind; op_data = a;
    if (kind == K_DIV) begin dv_a = a; dv_b = b; end
    if (kind == K_MULT) begin mu_a = a; mu_b = b; end
    rd = rd_pick(rd_mode, 0); rd_req = rd;
    @(negedge clk);
    chk1("ready_c0", op_ready, 1'b1);
    chk1("stall_c0", stall, 1'b0);
    if (rd) begin
      chk32("rd_hi_c0", hi, old_hi);
      chk32("rd_lo_c0", lo, old_lo);
    end
    tick();
    op_valid = 1'b0;
    if (kind == K_MTHI || kind == K_MTLO) begin
      rd_req = 1'b0;
      @(negedge clk);
      chk1("mt_busy", busy, 1'b0);
      chk1("mt_ready", op_ready, 1'b1);
      chk32("mt_hi", hi, ehi);
      chk32("mt_lo", lo, elo);
      tick();
    end else begin
      n = (kind == K_DIV) ? DN : MN;
      last = exc ? 2 : n;
      end_busy = exc ? 2 : n + 1;
      for (int k = 1; k <= end_busy + 2; k++) begin
        rd = rd_pick(rd_mode, k); rd_req = rd;
        @(negedge clk);
        commit_k = !exc && (k == n + 1);
        busy_e = (k <= end_busy);
        if (commit_k) begin
          hi_e = BYP ? ehi : old_hi; lo_e = BYP ? elo : old_lo;
        end else if (busy_e) begin
          hi_e = old_hi; lo_e = old_lo;
        end else begin
          hi_e = ehi; lo_e = elo;
        end
        chk1($sformatf("div_ctrl_c%0d", k), div_ctrl, (kind == K_DIV) && (k <= last));
        chk1($sformatf("mult_ctrl_c%0d", k), mult_ctrl, (kind == K_MULT) && (k <= last));
        chk1($sformatf("busy_c%0d", k), busy, busy_e);
        chk1($sformatf("ready_c%0d", k), op_ready, !busy_e);
        chk1($sformatf("exc_c%0d", k), div_zero_exc, exc && (k == 3));
        chk1($sformatf("stall_c%0d", k), stall, rd && busy_e && !(BYP && commit_k));
        chk32($sformatf("hi_c%0d", k), hi, hi_e);
        chk32($sformatf("lo_c%0d", k), lo, lo_e);
        tick();
      end
    end
    rd_req = 1'b0;
    hi_m = ehi; lo_m = elo;
  endtask

  typedef struct {
    logic [1:0]  kind;
    logic [31:0] a, b, ehi, elo;
    bit          exc;
    int          rd;
  } vec_t;

  vec_t tbl[10];

  initial begin
    logic [1:0]  rk;
    logic [31:0] ra, rb, rhi, rlo;
    logic [63:0] rr;
    bit          rexc;

    tbl[0] = '{K_MTHI, 32'hAAAA_0000, 32'd0, 32'hAAAA_0000, 32'h0000_0000, 1'b0, 0};
    tbl[1] = '{K_MTLO, 32'h0000_BBBB, 32'd0, 32'hAAAA_0000, 32'h0000_BBBB, 1'b0, 0};
    tbl[2] = '{K_DIV,  32'd5, 32'd0, 32'hAAAA_0000, 32'h0000_BBBB, 1'b1, 1};
    tbl[3] = '{K_DIV,  32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 0};
    tbl[4] = '{K_MULT, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 1'b0, 1};
    tbl[5] = '{K_DIV,  32'd100, 32'd7, 32'h0000_0002, 32'h0000_000E, 1'b0, 3};
    tbl[6] = '{K_MULT, 32'd3, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0, 2};
    tbl[7] = '{K_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0, 0};
    tbl[8] = '{K_DIV,  32'h8000_0000, 32'h0000_0010, 32'h0000_0000, 32'hF800_0000, 1'b0, 2};
    tbl[9] = '{K_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1};

    reset = 1'b0; op_valid = 1'b0; op_kind = 2'b00; op_data = 32'd0; rd_req = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk1("rst_div_ctrl", div_ctrl, 1'b0);
    chk1("rst_mult_ctrl", mult_ctrl, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_stall", stall, 1'b0);
    chk1("rst_exc", div_zero_exc, 1'b0);
    chk32("rst_hi", hi, 32'd0);
    chk32("rst_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b1; rd_req = 1'b0;
    tick();
    chk1("rst_ready", op_ready, 1'b1);
    hi_m = 32'd0; lo_m = 32'd0;

    for (int i = 0; i < 10; i++) begin
      run_op(tbl[i].kind, tbl[i].a, tbl[i].b, tbl[i].ehi, tbl[i].elo, tbl[i].exc, tbl[i].rd);
    end

    // MTHI then MTLO on consecutive cycles
    op_valid = 1'b1; op_kind = K_MTHI; op_data = 32'h1234_5678;
    tick();
    op_kind = K_MTLO; op_data = 32'hCAFE_BABE;
    @(negedge clk);
    chk32("mt2_hi_a", hi, 32'h1234_5678);
    chk1("mt2_busy_a", busy, 1'b0);
    chk1("mt2_ready_a", op_ready, 1'b1);
    tick();
    op_valid = 1'b0;
    @(negedge clk);
    chk32("mt2_hi_b", hi, 32'h1234_5678);
    chk32("mt2_lo_b", lo, 32'hCAFE_BABE);
    chk1("mt2_busy_b", busy, 1'b0);
    tick();
    hi_m = 32'h1234_5678; lo_m = 32'hCAFE_BABE;

    // MULT followed by an MTHI held pending; it must land in the first IDLE cycle
    op_valid = 1'b1; op_kind = K_MULT; mu_a = 32'd2; mu_b = 32'd3;
    tick();
    op_kind = K_MTHI; op_data = 32'h5555_AAAA;
    for (int k = 1; k <= 35; k++) begin
      @(negedge clk);
      chk1($sformatf("held_ready_c%0d", k), op_ready, 1'b0);
      if (k <= 34) chk32($sformatf("held_hi_c%0d", k), hi, hi_m);
      tick();
    end
    @(negedge clk);
    chk1("held_ready_c36", op_ready, 1'b1);
    chk32("held_hi_c36", hi, 32'd0);
    chk32("held_lo_c36", lo, 32'd6);
    tick();
    op_valid = 1'b0;
    @(negedge clk);
    chk32("held_hi_c37", hi, 32'h5555_AAAA);
    chk32("held_lo_c37", lo, 32'd6);
    chk1("held_busy_c37", busy, 1'b0);
    tick();
    hi_m = 32'h5555_AAAA; lo_m = 32'd6;

    // Reset in cycle 10 of a DIV
    op_valid = 1'b1; op_kind = K_DIV; dv_a = 32'd100; dv_b = 32'd7;
    tick();
    op_valid = 1'b0;
    repeat (9) tick();
    chk1("mid_div_ctrl_pre", div_ctrl, 1'b1);
    chk1("mid_busy_pre", busy, 1'b1);
    rd_req = 1'b1;
    reset = 1'b0;
    #1;
    chk1("mid_div_ctrl", div_ctrl, 1'b0);
    chk1("mid_busy", busy, 1'b0);
    chk1("mid_stall", stall, 1'b0);
    chk32("mid_hi", hi, 32'd0);
    chk32("mid_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b1; rd_req = 1'b0;
    tick();
    chk1("mid_ready", op_ready, 1'b1);
    hi_m = 32'd0; lo_m = 32'd0;
    run_op(K_DIV, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 0);

    // Randomized operations against the arithmetic model
    for (int i = 0; i < 40; i++) begin
      rk = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
      if (rb == 32'hFFFF_FFFF) rb = 32'd3;
      rhi = hi_m; rlo = lo_m; rexc = 1'b0;
      case (rk)
        K_MTHI: rhi = ra;
        K_MTLO: rlo = ra;
        K_MULT: begin
          rr = mul_ref(ra, rb); rhi = rr[63:32]; rlo = rr[31:0];
        end
        default: begin
          if (rb == 32'd0) rexc = 1'b1;
          else begin
            rr = div_ref(ra, rb); rhi = rr[63:32]; rlo = rr[31:0];
          end
        end
      endcase
      run_op(rk, ra, rb, rhi, rlo, rexc, 2);
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
